// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: I-cache and D-cache block fills (burst reads) and D-cache
// single-word writes onto one pipelined memory port, with return-word steering by index.
module mem_arbiter #(
   parameter int ADDR_WIDTH  = 16,
   parameter int BLOCK_WORDS = 8,
   parameter int READ_LAT    = 4
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_req,
   input  logic [ADDR_WIDTH-1:0]          i_addr,
   output logic                           i_grant,
   output logic                           i_rvalid,
   output logic                           i_done,
   input  logic                           d_req,
   input  logic                           d_wr,
   input  logic [ADDR_WIDTH-1:0]          d_addr,
   input  logic [15:0]                    d_wdata,
   output logic                           d_grant,
   output logic                           d_rvalid,
   output logic                           d_done,
   output logic [15:0]                    rd_data,
   output logic [$clog2(BLOCK_WORDS)-1:0] rd_idx,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   output logic                           mem_enable,
   output logic                           mem_wr,
   output logic [15:0]                    mem_wdata,
   input  logic [15:0]                    mem_rdata,
   input  logic                           mem_valid
);

   localparam int IDX_W = $clog2(BLOCK_WORDS);
   localparam int OFF   = IDX_W + 1;

   if (BLOCK_WORDS < 2 || READ_LAT < 1) begin : g_param_check
      $error("mem_arbiter: BLOCK_WORDS must be >= 2 and READ_LAT >= 1");
   end

   typedef enum logic [1:0] {IDLE, WRITE, ISSUE, DRAIN} state_t;

   state_t                  state, state_nxt;
   logic                    own_d;
   logic                    ptr_d;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [15:0]             wdata_q;
   logic [IDX_W-1:0]        iss_cnt;
   logic [IDX_W-1:0]        ret_cnt;
   logic                    accept;
   logic                    pick_d;
   logic                    ret;
   logic                    last_ret;

   // Pointer owner wins a tie; a lone requester always wins.
   assign pick_d   = d_req && (!i_req || ptr_d);
   assign accept   = (state == IDLE) && (i_req || d_req);
   assign ret      = ((state == ISSUE) || (state == DRAIN)) && mem_valid;
   assign last_ret = ret && (ret_cnt == IDX_W'(BLOCK_WORDS - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         own_d   <= 1'b0;
         ptr_d   <= 1'b1;
         addr_q  <= '0;
         wdata_q <= '0;
         iss_cnt <= '0;
         ret_cnt <= '0;
      end else begin
         if (accept) begin
            own_d   <= pick_d;
            addr_q  <= pick_d ? d_addr : i_addr;
            wdata_q <= d_wdata;
            iss_cnt <= '0;
            ret_cnt <= '0;
            if (i_req && d_req) ptr_d <= !pick_d;
         end
         // Both counters wrap to zero on their final increment, leaving them clean for IDLE.
         if (state == ISSUE) iss_cnt <= iss_cnt + IDX_W'(1);
         if (ret)            ret_cnt <= ret_cnt + IDX_W'(1);
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (accept) state_nxt = (pick_d && d_wr) ? WRITE : ISSUE;
         WRITE: state_nxt = IDLE;
         ISSUE: if (iss_cnt == IDX_W'(BLOCK_WORDS - 1)) state_nxt = DRAIN;
         DRAIN: if (last_ret) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      i_grant    = 1'b0;
      d_grant    = 1'b0;
      i_rvalid   = 1'b0;
      d_rvalid   = 1'b0;
      i_done     = 1'b0;
      d_done     = 1'b0;
      rd_data    = '0;
      rd_idx     = '0;
      mem_enable = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      if (state != IDLE) begin
         i_grant = !own_d;
         d_grant = own_d;
      end
      if (ret) begin
         i_rvalid = !own_d;
         d_rvalid = own_d;
         rd_data  = mem_rdata;
         rd_idx   = ret_cnt;
      end
      i_done = last_ret && !own_d;
      d_done = (last_ret && own_d) || (state == WRITE);
      if (state == WRITE) begin
         mem_enable = 1'b1;
         mem_wr     = 1'b1;
         mem_addr   = {addr_q[ADDR_WIDTH-1:1], 1'b0};
         mem_wdata  = wdata_q;
      end else if (state == ISSUE) begin
         mem_enable = 1'b1;
         mem_addr   = {addr_q[ADDR_WIDTH-1:OFF], iss_cnt, 1'b0};
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: pipelined memory model, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_mem_arbiter;

   localparam int AW  = 16;
   localparam int BW  = 8;
   localparam int LAT = 4;
   localparam int IW  = $clog2(BW);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
   logic [15:0]   i_addr = '0, d_addr = '0, d_wdata = '0;
   logic          i_grant, i_rvalid, i_done, d_grant, d_rvalid, d_done;
   logic [15:0]   rd_data, mem_addr, mem_wdata, mem_rdata;
   logic [IW-1:0] rd_idx;
   logic          mem_enable, mem_wr, mem_valid;
   logic          force_v = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_n   = 0;

   mem_arbiter #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW), .READ_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_grant(i_grant), .i_rvalid(i_rvalid), .i_done(i_done),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_grant(d_grant), .d_rvalid(d_rvalid), .d_done(d_done),
      .rd_data(rd_data), .rd_idx(rd_idx),
      .mem_addr(mem_addr), .mem_enable(mem_enable), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   function automatic logic [15:0] init_word(input int unsigned w);
      return 16'(w * 40503) ^ 16'h1357;
   endfunction

   // Memory: contents stored as a delta against init_word so no initialisation pass is needed.
   bit   [15:0] mem_delta [32768];
   logic        pv [LAT];
   logic [15:0] pd [LAT];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            pv[i] <= 1'b0;
            pd[i] <= '0;
         end
      end else begin
         for (int i = LAT - 1; i > 0; i--) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
         end
         pv[0] <= mem_enable && !mem_wr;
         pd[0] <= mem_delta[mem_addr[15:1]] ^ init_word(int'(mem_addr[15:1]));
         if (mem_enable && mem_wr)
            mem_delta[mem_addr[15:1]] <= mem_wdata ^ init_word(int'(mem_addr[15:1]));
      end
   end

   assign mem_valid = pv[LAT-1] | force_v;
   assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : (force_v ? 16'hDEAD : 16'h0000);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc_n, act, exp);
      end
   endtask

   // Reference model: one transaction at a time described by its start cycle and kind.
   bit   [15:0] sh_delta [32768];
   bit          m_act = 1'b0, m_d = 1'b0, m_wr = 1'b0, m_ptr_d = 1'b1;
   int          m_s = 0, m_end = 0;
   logic [15:0] m_addr = '0, m_wdata = '0, m_base = '0;
   int          mk, mj;
   logic        e_ig, e_irv, e_idn, e_dg, e_drv, e_ddn, e_en, e_wr;
   logic [15:0] e_addr, e_data;
   logic [IW-1:0] e_idx;
   bit          pick_d;

   always @(negedge clk) begin
      if (rst) begin
         m_act   = 1'b0;
         m_ptr_d = 1'b1;
      end else begin
         {e_ig, e_irv, e_idn, e_dg, e_drv, e_ddn, e_en, e_wr} = '0;
         e_addr = '0; e_data = '0; e_idx = '0;
         if (m_act && cyc_n >= m_s && cyc_n <= m_end) begin
            mk = cyc_n - m_s;
            if (m_wr) begin
               {e_dg, e_en, e_wr, e_ddn} = 4'b1111;
               e_addr = {m_addr[15:1], 1'b0};
            end else begin
               if (m_d) e_dg = 1'b1; else e_ig = 1'b1;
               if (mk < BW) begin
                  e_en   = 1'b1;
                  e_addr = m_base + 16'(2 * mk);
               end
               mj = mk - LAT;
               if (mj >= 0 && mj < BW) begin
                  if (m_d) e_drv = 1'b1; else e_irv = 1'b1;
                  e_idx  = IW'(mj);
                  e_data = sh_delta[m_base[15:1] + 15'(mj)] ^ init_word(int'(m_base[15:1]) + mj);
                  if (mj == BW - 1) begin
                     if (m_d) e_ddn = 1'b1; else e_idn = 1'b1;
                  end
               end
            end
         end
         check("ctl", 32'({i_grant, i_rvalid, i_done, d_grant, d_rvalid, d_done, mem_enable, mem_wr}),
               32'({e_ig, e_irv, e_idn, e_dg, e_drv, e_ddn, e_en, e_wr}));
         if (e_en || !(m_act && cyc_n >= m_s && cyc_n <= m_end))
            check("mem_addr", 32'(mem_addr), 32'(e_addr));
         if (e_wr) check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
         if (e_irv || e_drv) check("rd_idx_data", 32'({rd_idx, rd_data}), 32'({e_idx, e_data}));

         if ((!m_act || cyc_n > m_end) && (i_req || d_req)) begin
            pick_d = d_req && (!i_req || m_ptr_d);
            if (i_req && d_req) m_ptr_d = !pick_d;
            m_act   = 1'b1;
            m_d     = pick_d;
            m_wr    = pick_d && d_wr;
            m_addr  = pick_d ? d_addr : i_addr;
            m_wdata = d_wdata;
            m_base  = m_addr & ~16'(2 * BW - 1);
            m_s     = cyc_n + 1;
            m_end   = m_wr ? cyc_n + 1 : cyc_n + BW + LAT;
            if (m_wr) sh_delta[m_addr[15:1]] = m_wdata ^ init_word(int'(m_addr[15:1]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit for_d, output int n, output logic [15:0] cap1);
      cap1 = 'x;
      for (int i = 1; i <= 40; i++) begin
         step();
         if ((for_d ? d_rvalid : i_rvalid) && rd_idx == IW'(1)) cap1 = rd_data;
         if (for_d ? d_done : i_done) begin
            n = i;
            return;
         end
      end
      n = -1;
      n_tests++;
      n_fail++;
      $display("FAIL wait_done(%0d): no done within 40 cycles", for_d);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hi, hd;
      logic [15:0] cap;
      bit idle_now;

      do_reset();
      check("reset_outputs", 32'({i_grant, i_rvalid, i_done, d_grant, d_rvalid, d_done,
                                   mem_enable, mem_wr, mem_addr}), 32'h0);

      // Lone I-cache fill: addresses, latency from first read to done, last index.
      i_req = 1'b1; i_addr = 16'h1236;
      step();
      i_req = 1'b0;
      check("t1_first_addr", 32'({i_grant, mem_enable, mem_addr}), 32'({2'b11, 16'h1230}));
      for (int k = 1; k <= 7; k++) step();
      check("t1_last_addr", 32'(mem_addr), 32'h123E);
      wait_done(1'b0, n, cap);
      check("t1_done_latency", 32'(n + 7), 32'd11);
      check("t1_done_idx", 32'({rd_idx, d_grant, d_rvalid}), 32'({3'd7, 2'b00}));
      step();

      // D-cache write then readback fill of the same block.
      d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0043; d_wdata = 16'hBEEF;
      step();
      d_req = 1'b0; d_wr = 1'b0;
      check("t2_write_bus", 32'({mem_enable, mem_wr, d_done, mem_addr}), 32'({3'b111, 16'h0042}));
      check("t2_write_data", 32'(mem_wdata), 32'hBEEF);
      step();
      d_req = 1'b1; d_addr = 16'h0040;
      step();
      d_req = 1'b0;
      wait_done(1'b1, n, cap);
      check("t2_readback", 32'(cap), 32'hBEEF);
      step();

      // Simultaneous requests: D first after reset, then alternation.
      do_reset();
      i_req = 1'b1; i_addr = 16'h2000; d_req = 1'b1; d_addr = 16'h3000;
      step();
      d_req = 1'b0;
      check("t3_d_first", 32'({d_grant, i_grant}), 32'b10);
      wait_done(1'b1, n, cap);
      step();
      step();
      i_req = 1'b0;
      check("t3_i_after_d", 32'({d_grant, i_grant}), 32'b01);
      wait_done(1'b0, n, cap);
      step();
      i_req = 1'b1; d_req = 1'b1;
      step();
      i_req = 1'b0;
      check("t3_i_second_pair", 32'({d_grant, i_grant}), 32'b01);
      wait_done(1'b0, n, cap);
      step();
      step();
      d_req = 1'b0;
      check("t3_d_after_i", 32'({d_grant, i_grant}), 32'b10);
      wait_done(1'b1, n, cap);
      step();

      // D request raised mid I-burst waits for I to finish.
      i_req = 1'b1; i_addr = 16'h4444;
      step();
      i_req = 1'b0;
      repeat (3) step();
      d_req = 1'b1; d_addr = 16'h5550;
      wait_done(1'b0, n, cap);
      step();
      step();
      d_req = 1'b0;
      check("t4_d_granted_after", 32'({d_grant, i_grant}), 32'b10);
      wait_done(1'b1, n, cap);
      step();

      // Reset in DRAIN kills the transaction; a fresh one completes normally.
      i_req = 1'b1; i_addr = 16'h6000;
      step();
      i_req = 1'b0;
      repeat (9) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t5_post_reset_ctl", 32'({i_grant, i_rvalid, i_done, d_grant, d_rvalid, d_done,
                                       mem_enable, mem_wr, mem_addr}), 32'h0);
      check("t5_post_reset_data", 32'({rd_idx, rd_data, mem_wdata}), 32'h0);
      repeat (5) step();
      d_req = 1'b1; d_addr = 16'h7000;
      step();
      d_req = 1'b0;
      wait_done(1'b1, n, cap);
      check("t5_fresh_latency", 32'(n), 32'd11);
      step();

      // Spurious memory valid while idle.
      force_v = 1'b1;
      repeat (3) begin
         check("t6_no_rvalid", 32'({i_rvalid, d_rvalid, i_done, d_done}), 32'h0);
         step();
      end
      force_v = 1'b0;
      step();

      // Randomized traffic obeying the request protocol.
      hi = 0; hd = 0;
      for (int c = 0; c < 2500; c++) begin
         if (i_req && i_grant) begin
            i_req = 1'b0; hi = $urandom_range(0, 6);
         end else if (!i_req && !i_grant) begin
            if (hi > 0) hi--;
            else if ($urandom_range(0, 3) == 0) begin
               i_req = 1'b1; i_addr = 16'($urandom);
            end
         end
         if (d_req && d_grant) begin
            d_req = 1'b0; hd = $urandom_range(0, 6);
         end else if (!d_req && !d_grant) begin
            if (hd > 0) hd--;
            else if ($urandom_range(0, 3) == 0) begin
               d_req   = 1'b1;
               d_wr    = ($urandom_range(0, 2) == 0);
               d_addr  = 16'($urandom_range(0, 255)) ^ 16'h8000;
               d_wdata = 16'($urandom);
            end
         end
         rst      = ($urandom_range(0, 299) == 0);
         idle_now = !m_act || (cyc_n > m_end);
         force_v  = idle_now && !rst && ($urandom_range(0, 7) == 0);
         step();
      end
      rst = 1'b0; force_v = 1'b0; i_req = 1'b0; d_req = 1'b0;
      repeat (20) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
